led_mode_sequencer: RTL and testbench



---
 rtl/led_mode_sequencer.sv | 141 ++++++++++++++
 tb/tb_led_mode_sequencer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/led_mode_sequencer.sv
// Button-driven LED mode sequencer: synchronizes and debounces a raw push button,
// steps a four-mode FSM on each debounced press and drives two LEDs from a shared blink timer.
module led_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int BLINK_HALF_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_button,
  output logic       led_on_0,
  output logic       led_on_1,
  output logic [1:0] mode
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int BW = $clog2(BLINK_HALF_CYCLES);
  localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    BLINK0 = 2'd1,
    ALT    = 2'd2,
    BOTH   = 2'd3
  } mode_t;

  logic          sync1;
  logic          sync2;
  logic          db;
  logic          db_d;
  logic [DW-1:0] dcnt;
  logic          press;
  logic [BW-1:0] bcnt;
  logic          phase;
  mode_t         mode_q;
  mode_t         mode_nxt;

  // Two-flop synchronizer on the asynchronous button pin
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= push_button;
      sync2 <= sync1;
    end
  end

  // Debounce: level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db   <= 1'b0;
      dcnt <= '0;
    end else if (sync2 == db) begin
      dcnt <= '0;
    end else if (dcnt == DCNT_MAX) begin
      db   <= sync2;
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_d <= 1'b0;
    end else begin
      db_d <= db;
    end
  end

  assign press = db & ~db_d;

  // A press restarts the blink with a full "on" half-period, taking priority over a wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (press) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == BCNT_MAX) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt  <= bcnt + BW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= OFF;
    end else begin
      mode_q <= mode_nxt;
    end
  end

  always_comb begin
    mode_nxt = mode_q;
    if (press) begin
      unique case (mode_q)
        OFF:     mode_nxt = BLINK0;
        BLINK0:  mode_nxt = ALT;
        ALT:     mode_nxt = BOTH;
        BOTH:    mode_nxt = OFF;
        default: mode_nxt = OFF;
      endcase
    end
  end

  // LEDs decode only registered state, so they cannot glitch
  always_comb begin
    led_on_0 = 1'b0;
    led_on_1 = 1'b0;
    unique case (mode_q)
      OFF: begin
        led_on_0 = 1'b0;
        led_on_1 = 1'b0;
      end
      BLINK0: begin
        led_on_0 = phase;
        led_on_1 = 1'b0;
      end
      ALT: begin
        led_on_0 = phase;
        led_on_1 = ~phase;
      end
      BOTH: begin
        led_on_0 = phase;
        led_on_1 = phase;
      end
      default: begin
        led_on_0 = 1'b0;
        led_on_1 = 1'b0;
      end
    endcase
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer: reset, glitch rejection, press latency,
// blink timing per mode, held button, press/wrap collision and asynchronous reset.
module tb_led_mode_sequencer;

  localparam int DC  = 4;
  localparam int BH  = 8;
  localparam int LAT = DC + 2;

  logic       clk;
  logic       rst;
  logic       push_button;
  logic       led_on_0;
  logic       led_on_1;
  logic [1:0] mode;

  int checks     = 0;
  int failures   = 0;
  int model_mode = 0;
  int exp_q[$];

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES  (DC),
    .BLINK_HALF_CYCLES(BH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .push_button(push_button),
    .led_on_0   (led_on_0),
    .led_on_1   (led_on_1),
    .mode       (mode)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at a falling edge: raise the button, hold it, release it, and score the advance
  task automatic press_cycle(input int hold, input int rel, input bit collide);
    int         seen;
    int         nchg;
    int         m;
    int         ph;
    int         e0;
    int         e1;
    logic [1:0] prev;
    seen = -1;
    nchg = 0;
    m    = 0;
    prev = model_mode[1:0];
    model_mode = (model_mode + 1) % 4;
    exp_q.push_back(model_mode);
    push_button = 1'b1;
    for (int k = 0; k < hold + rel; k++) begin
      @(posedge clk);
      #1;
      if (mode !== prev) begin
        nchg++;
        prev = mode;
        if (seen < 0) begin
          seen = k;
          m = exp_q.pop_front();
          chk("mode_adv", mode, m);
          if (collide) begin
            chk("collide_phase", dut.phase, 1);
            chk("collide_bcnt", dut.bcnt, 0);
          end
        end
      end
      if (seen >= 0) begin
        ph = (((k - seen) / BH) % 2 == 0) ? 1 : 0;
        e0 = (m == 0) ? 0 : ph;
        e1 = (m == 0 || m == 1) ? 0 : (m == 2) ? (1 - ph) : ph;
        chk("led0_blink", led_on_0, e0);
        chk("led1_blink", led_on_1, e1);
      end
      @(negedge clk);
      if (k == hold - 1) push_button = 1'b0;
    end
    if (exp_q.size() > 0) chk("mode_adv", mode, exp_q.pop_front());
    chk("press_latency", seen, LAT);
    chk("advance_count", nchg, 1);
  endtask

  initial begin
    int bad;
    rst         = 1'b0;
    push_button = 1'b0;

    // Asynchronous reset asserted mid-cycle
    #3 rst = 1'b1;
    #1;
    chk("rst_led0", led_on_0, 0);
    chk("rst_led1", led_on_1, 0);
    chk("rst_mode", mode, 0);
    repeat (5) begin
      @(negedge clk);
      push_button = ~push_button;
      @(posedge clk);
      #1;
      chk("rst_hold_mode", mode, 0);
      chk("rst_hold_leds", {led_on_1, led_on_0}, 0);
    end
    @(negedge clk);
    push_button = 1'b0;
    rst = 1'b0;
    model_mode = 0;

    // Short glitch: sampled high for only two edges
    @(posedge clk);
    #5 push_button = 1'b1;
    #50 push_button = 1'b0;
    bad = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (mode !== 2'd0) bad++;
    end
    chk("glitch_mode", mode, 0);
    chk("glitch_changes", bad, 0);

    // Full mode cycle; the first press also covers a complete blink period
    @(negedge clk);
    press_cycle(10, 22, 1'b0);
    press_cycle(10, 10, 1'b0);
    press_cycle(10, 10, 1'b0);
    press_cycle(10, 10, 1'b0);
    chk("final_mode", mode, 0);
    chk("final_leds", {led_on_1, led_on_0}, 0);

    // Held button, release sized so the next update edge lands on a blink wrap
    press_cycle(200, 16, 1'b0);
    press_cycle(10, 10, 1'b1);

    // Reset while in ALT with phase low
    for (int i = 0; i < 40 && led_on_0 !== 1'b0; i++) @(negedge clk);
    chk("alt_phase0_led1", led_on_1, 1);
    chk("alt_mode", mode, 2);
    #3 rst = 1'b1;
    #1;
    chk("midrst_led0", led_on_0, 0);
    chk("midrst_led1", led_on_1, 0);
    chk("midrst_mode", mode, 0);
    model_mode = 0;
    @(negedge clk);
    rst = 1'b0;

    // Operation resumes after reset release
    @(negedge clk);
    press_cycle(10, 10, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
